hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset: asynchronous and active-high.
REQ-003 SHALL have ports ra1D and ra2D, input, 5 each, the rs and rt source addresses of the instruction in D.
REQ-004 SHALL have ports tuseRsD and tuseRtD, input, 2 each, the stage-use time: 0 = needed in D, 1 = needed in E, 3 = unused.
REQ-005 SHALL have ports waE and waM, input, 5 each, the write addresses of the E and M instructions.
REQ-006 SHALL have ports resE and resM, input, 3 each, result class: 0 NW, 1 ALU, 2 DM, 3 PC, 4 MD.
REQ-007 SHALL have port mdUseD, input, 1: the D instruction reads or writes the mult/div unit.
REQ-008 SHALL have ports mdStartE and mdIsDivE, input, 1 each: a mult/div starts in E; 1 = divide.
REQ-009 SHALL have ports excReqM and eretD, input, 1 each: exception or interrupt taken at M; eret in D.
REQ-010 SHALL have port stall, output, 1: freeze PC and F/D, clear D/E.
REQ-011 SHALL have port DEMWclr, output, 1: flush the D/E, E/M and M/W pipeline registers.
REQ-012 SHALL have port pcExc, output, 1: select the handler address for PC.
REQ-013 SHALL have port mdBusy, output, 1: the mult/div unit is occupied.

Function
REQ-014 SHALL derive Tnew combinationally: E ALU/MD = 1, E DM = 2, M DM = 1; everything else = 0.
REQ-015 SHALL assert a data stall when, for rs or rt, the address is nonzero, equals waE (resE != NW) or waM (resM != NW), and tuse < Tnew of that stage.
REQ-016 SHALL assert an MD stall when mdUseD = 1 and (mdBusy = 1 or mdStartE = 1).
REQ-017 SHALL drive stall = data stall OR MD stall, qualified by state == RUN.
REQ-018 SHALL run a state machine with states RUN, FLUSH and ERETW.
REQ-019 SHALL take the transition RUN -> FLUSH on excReqM.
REQ-020 SHALL take the transition FLUSH -> RUN unconditionally after one cycle.
REQ-021 SHALL take the transition RUN -> ERETW on eretD when there is no stall.
REQ-022 SHALL take the transition ERETW -> RUN after one cycle.
REQ-023 SHALL drive DEMWclr = 1 and pcExc = 1 in the same cycle as excReqM, combinationally, and hold both through FLUSH.
REQ-024 SHALL drive stall = 1 in ERETW, a one-cycle fetch bubble while EPC settles.
REQ-025 SHALL give excReqM priority over eretD and over any stall; stall = 0 whenever DEMWclr = 1.
REQ-026 SHALL load a 4-bit busy counter on mdStartE with 5 (mult) or 10 (div) and decrement it to 0; mdBusy = (count != 0).
REQ-027 SHALL ignore mdStartE when excReqM is high in the same cycle.
REQ-028 SHALL NOT stop or clear a counter already running because of an exception.
REQ-029 SHALL restart the counter from the new value when mdStartE arrives while it is nonzero.

Reset
REQ-030 SHALL set state = RUN and counter = 0 on rst, immediately and asynchronously.
REQ-031 SHALL hold outputs at stall = 0, DEMWclr = 0, pcExc = 0 and mdBusy = 0 while rst is high.
REQ-032 SHALL abandon a FLUSH, ERETW or a count in progress when rst arrives mid-operation.

Configuration
REQ-033 SHALL, with HZ_MD_BUSY_EN defined, implement the counter and MD stall per REQ-016 and REQ-026 to REQ-029.
REQ-034 SHALL, without HZ_MD_BUSY_EN, omit the counter, tie mdBusy = 0, omit the MD stall and ignore the md* inputs.

Structure
REQ-035 SHALL place the res class codes, tuse codes, state encoding and the MD latencies (5/10) in the shared package hz_pkg.
REQ-036 SHALL implement the counter as sub-module md_busy_cnt (clk, rst, start, isDiv, kill, busy).

Verification
REQ-037 SHALL cover a load-use case: resE = DM, waE = 8, ra1D = 8, tuseRsD = 1 -> stall = 1 for exactly one cycle, then 0 once the load reaches M.
REQ-038 SHALL cover the $0 case: waE = 0, resE = ALU, ra1D = 0, tuseRsD = 0 -> stall = 0.
REQ-039 SHALL cover a divide: mdStartE with isDiv = 1, then mdUseD held -> mdBusy high for 10 cycles, stall high for 11 cycles including the start cycle.
REQ-040 SHALL cover an exception during a stall: excReqM = 1 while a data stall is pending -> stall = 0, DEMWclr = 1 and pcExc = 1 for two cycles, state back to RUN.
REQ-041 SHALL cover eret: eretD = 1 with no hazard -> stall = 1 for one cycle (ERETW).
REQ-042 SHALL cover reset mid-operation: rst pulsed mid-divide (count = 6) -> mdBusy drops asynchronously, state = RUN.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: result classes, use-time
// codes, controller states and mult/div latencies, plus the Tnew and
// per-source hazard decode helpers.
package hz_pkg;

    typedef enum logic [2:0] {
        RES_NW  = 3'd0,
        RES_ALU = 3'd1,
        RES_DM  = 3'd2,
        RES_PC  = 3'd3,
        RES_MD  = 3'd4
    } res_class_e;

    localparam logic [1:0] TUSE_D    = 2'd0;
    localparam logic [1:0] TUSE_E    = 2'd1;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_ERETW = 2'd2
    } state_e;

    localparam logic [3:0] MD_LAT_MULT = 4'd5;
    localparam logic [3:0] MD_LAT_DIV  = 4'd10;

    // Cycles until the E-stage instruction's result is forwardable.
    function automatic logic [1:0] tnew_e(input logic [2:0] res);
        logic [1:0] t;
        case (res)
            3'(RES_ALU): t = 2'd1;
            3'(RES_MD):  t = 2'd1;
            3'(RES_DM):  t = 2'd2;
            default:     t = 2'd0;
        endcase
        return t;
    endfunction

    // Cycles until the M-stage instruction's result is forwardable.
    function automatic logic [1:0] tnew_m(input logic [2:0] res);
        logic [1:0] t;
        case (res)
            3'(RES_DM): t = 2'd1;
            default:    t = 2'd0;
        endcase
        return t;
    endfunction

    // One source operand needs a value that no stage can forward in time.
    // A use time of TUSE_NONE (3) is never below any Tnew, so it never stalls.
    function automatic logic src_hazard(
        input logic [4:0] addr,
        input logic [1:0] tuse,
        input logic [4:0] wa_e,
        input logic [2:0] res_e_v,
        input logic [4:0] wa_m,
        input logic [2:0] res_m_v
    );
        logic hit_e;
        logic hit_m;
        hit_e = (addr == wa_e) && (res_e_v != 3'(RES_NW)) && (tuse < tnew_e(res_e_v));
        hit_m = (addr == wa_m) && (res_m_v != 3'(RES_NW)) && (tuse < tnew_m(res_m_v));
        return (addr != 5'd0) && (hit_e || hit_m);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. The pipeline (master) drives
// the decode/execute/memory status; the controller (slave) returns the
// stall, flush, exception-vector and mult/div busy controls.
interface hazard_ctrl_if;
    logic [4:0] ra1D;
    logic [4:0] ra2D;
    logic [1:0] tuseRsD;
    logic [1:0] tuseRtD;
    logic [4:0] waE;
    logic [4:0] waM;
    logic [2:0] resE;
    logic [2:0] resM;
    logic       mdUseD;
    logic       mdStartE;
    logic       mdIsDivE;
    logic       excReqM;
    logic       eretD;
    logic       stall;
    logic       DEMWclr;
    logic       pcExc;
    logic       mdBusy;

    modport master (
        output ra1D, ra2D, tuseRsD, tuseRtD, waE, waM, resE, resM,
        output mdUseD, mdStartE, mdIsDivE, excReqM, eretD,
        input  stall, DEMWclr, pcExc, mdBusy
    );

    modport slave (
        input  ra1D, ra2D, tuseRsD, tuseRtD, waE, waM, resE, resM,
        input  mdUseD, mdStartE, mdIsDivE, excReqM, eretD,
        output stall, DEMWclr, pcExc, mdBusy
    );
endinterface

// File: rtl/hazard_ctrl_md_busy_cnt.sv
// Mult/div occupancy counter. A start loads the operation latency, the
// count then runs down to zero; busy is high while it is nonzero. A start
// in the same cycle as kill (exception at M) is discarded, but a count
// already in flight keeps running.
module md_busy_cnt
    import hz_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic isDiv,
    input  logic kill,
    output logic busy
);

    logic [3:0] count_r;

    // Load on a surviving start (restarting if already busy), else count down.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= 4'd0;
        end else if (start && !kill) begin
            count_r <= isDiv ? MD_LAT_DIV : MD_LAT_MULT;
        end else if (count_r != 4'd0) begin
            count_r <= count_r - 4'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign busy = (count_r != 4'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: data-hazard stall from Tuse/Tnew comparison,
// mult/div stall, exception flush and eret fetch bubble.
// Optional feature macro: HZ_MD_BUSY_EN -- when defined, the mult/div busy
// counter and its stall are built; otherwise mdBusy is tied low and the md*
// inputs are ignored.
module hazard_ctrl
    import hz_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  bus
);

    state_e state_r;
    state_e state_nxt_s;
    logic   data_stall_s;
    logic   md_stall_s;
    logic   md_busy_s;
    logic   stall_s;
    logic   clr_s;

    // Data hazard on either source operand of the D-stage instruction.
    always_comb begin
        data_stall_s = src_hazard(bus.ra1D, bus.tuseRsD, bus.waE, bus.resE, bus.waM, bus.resM)
                     | src_hazard(bus.ra2D, bus.tuseRtD, bus.waE, bus.resE, bus.waM, bus.resM);
    end

`ifdef HZ_MD_BUSY_EN
    md_busy_cnt u_md_busy_cnt (
        .clk   (clk),
        .rst   (rst),
        .start (bus.mdStartE),
        .isDiv (bus.mdIsDivE),
        .kill  (bus.excReqM),
        .busy  (md_busy_s)
    );

    // A D-stage mult/div access must wait for the unit, including one starting in E.
    always_comb begin
        md_stall_s = bus.mdUseD & (md_busy_s | bus.mdStartE);
    end
`else
    logic unused_md_s;

    // Mult/div tracking not built: the unit never appears busy.
    always_comb begin
        md_busy_s   = 1'b0;
        md_stall_s  = 1'b0;
        unused_md_s = &{1'b0, bus.mdUseD, bus.mdStartE, bus.mdIsDivE};
    end
`endif

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and control decode; an exception outranks eret and stalls.
    always_comb begin
        state_nxt_s = state_r;
        stall_s     = 1'b0;
        clr_s       = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (bus.excReqM) begin
                    clr_s       = 1'b1;
                    state_nxt_s = ST_FLUSH;
                end else if (data_stall_s || md_stall_s) begin
                    stall_s     = 1'b1;
                    state_nxt_s = ST_RUN;
                end else if (bus.eretD) begin
                    state_nxt_s = ST_ERETW;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                clr_s       = 1'b1;
                state_nxt_s = ST_RUN;
            end
            ST_ERETW: begin
                state_nxt_s = ST_RUN;
                if (bus.excReqM) begin
                    clr_s = 1'b1;
                end else begin
                    stall_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // Outputs are forced low for as long as reset is held.
    always_comb begin
        bus.stall   = stall_s & ~rst;
        bus.DEMWclr = clr_s & ~rst;
        bus.pcExc   = clr_s & ~rst;
        bus.mdBusy  = md_busy_s & ~rst;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a decode vector table plus
// hand-written multi-cycle sequences, all checked through a scoreboard queue.
module tb_hazard_ctrl;
    import hz_pkg::*;

`ifdef HZ_MD_BUSY_EN
    localparam logic MD_EN = 1'b1;
`else
    localparam logic MD_EN = 1'b0;
`endif

    typedef struct {
        logic [4:0] ra1;
        logic [4:0] ra2;
        logic [1:0] tr;
        logic [1:0] tt;
        logic [4:0] wae;
        logic [4:0] wam;
        logic [2:0] rese;
        logic [2:0] resm;
        logic       mduse;
        logic       exp_stall;
    } vec_t;

    typedef struct {
        string name;
        logic  stall;
        logic  clr;
        logic  pcexc;
        logic  busy;
    } exp_t;

    logic   clk;
    logic   rst;
    int     n_checks;
    int     n_errors;
    exp_t   sb_q[$];
    vec_t   vecs[16];

    hazard_ctrl_if bus();

    hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [4:0] ra1, input logic [4:0] ra2,
                                input logic [1:0] tr, input logic [1:0] tt,
                                input logic [4:0] wae, input logic [4:0] wam,
                                input logic [2:0] rese, input logic [2:0] resm,
                                input logic mduse, input logic exp_stall);
        vec_t v;
        v.ra1 = ra1; v.ra2 = ra2; v.tr = tr; v.tt = tt;
        v.wae = wae; v.wam = wam; v.rese = rese; v.resm = resm;
        v.mduse = mduse; v.exp_stall = exp_stall;
        return v;
    endfunction

    task automatic cmp(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        bus.ra1D = 5'd0; bus.ra2D = 5'd0;
        bus.tuseRsD = TUSE_NONE; bus.tuseRtD = TUSE_NONE;
        bus.waE = 5'd0; bus.waM = 5'd0;
        bus.resE = 3'(RES_NW); bus.resM = 3'(RES_NW);
        bus.mdUseD = 1'b0; bus.mdStartE = 1'b0; bus.mdIsDivE = 1'b0;
        bus.excReqM = 1'b0; bus.eretD = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Push the expectation for the inputs just driven, then pop and compare
    // it at the falling edge, away from the active edge.
    task automatic expect_now(input string nm, input logic s, input logic c,
                              input logic p, input logic b);
        exp_t e;
        exp_t got;
        e.name = nm; e.stall = s; e.clr = c; e.pcexc = p; e.busy = b;
        sb_q.push_back(e);
        @(negedge clk);
        got = sb_q.pop_front();
        cmp({got.name, ".stall"},   bus.stall,   got.stall);
        cmp({got.name, ".DEMWclr"}, bus.DEMWclr, got.clr);
        cmp({got.name, ".pcExc"},   bus.pcExc,   got.pcexc);
        cmp({got.name, ".mdBusy"},  bus.mdBusy,  got.busy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;

        vecs[0]  = mk(5'd0,  5'd0, 2'd3, 2'd3, 5'd0,  5'd0, 3'(RES_NW),  3'(RES_NW),  1'b0, 1'b0);
        vecs[1]  = mk(5'd5,  5'd0, 2'd0, 2'd3, 5'd5,  5'd0, 3'(RES_ALU), 3'(RES_NW),  1'b0, 1'b1);
        vecs[2]  = mk(5'd5,  5'd0, 2'd1, 2'd3, 5'd5,  5'd0, 3'(RES_ALU), 3'(RES_NW),  1'b0, 1'b0);
        vecs[3]  = mk(5'd0,  5'd8, 2'd3, 2'd1, 5'd8,  5'd0, 3'(RES_DM),  3'(RES_NW),  1'b0, 1'b1);
        vecs[4]  = mk(5'd0,  5'd8, 2'd3, 2'd3, 5'd8,  5'd0, 3'(RES_DM),  3'(RES_NW),  1'b0, 1'b0);
        vecs[5]  = mk(5'd9,  5'd0, 2'd0, 2'd3, 5'd0,  5'd9, 3'(RES_NW),  3'(RES_DM),  1'b0, 1'b1);
        vecs[6]  = mk(5'd9,  5'd0, 2'd1, 2'd3, 5'd0,  5'd9, 3'(RES_NW),  3'(RES_DM),  1'b0, 1'b0);
        vecs[7]  = mk(5'd9,  5'd0, 2'd0, 2'd3, 5'd0,  5'd9, 3'(RES_NW),  3'(RES_ALU), 1'b0, 1'b0);
        vecs[8]  = mk(5'd0,  5'd0, 2'd0, 2'd3, 5'd0,  5'd0, 3'(RES_ALU), 3'(RES_NW),  1'b0, 1'b0);
        vecs[9]  = mk(5'd5,  5'd0, 2'd0, 2'd3, 5'd5,  5'd0, 3'(RES_NW),  3'(RES_NW),  1'b0, 1'b0);
        vecs[10] = mk(5'd0,  5'd7, 2'd3, 2'd0, 5'd7,  5'd0, 3'(RES_MD),  3'(RES_NW),  1'b0, 1'b1);
        vecs[11] = mk(5'd31, 5'd0, 2'd0, 2'd3, 5'd31, 5'd0, 3'(RES_PC),  3'(RES_NW),  1'b0, 1'b0);
        vecs[12] = mk(5'd5,  5'd0, 2'd0, 2'd3, 5'd4,  5'd0, 3'(RES_ALU), 3'(RES_NW),  1'b0, 1'b0);
        vecs[13] = mk(5'd0,  5'd0, 2'd3, 2'd3, 5'd0,  5'd0, 3'(RES_NW),  3'(RES_NW),  1'b1, 1'b0);
        vecs[14] = mk(5'd3,  5'd3, 2'd0, 2'd0, 5'd3,  5'd6, 3'(RES_DM),  3'(RES_DM),  1'b0, 1'b1);
        vecs[15] = mk(5'd0,  5'd6, 2'd3, 2'd0, 5'd0,  5'd6, 3'(RES_NW),  3'(RES_DM),  1'b0, 1'b1);

        // Reset holds every output low even with a hazard and exception present.
        rst = 1'b1;
        drive_idle();
        bus.excReqM = 1'b1; bus.ra1D = 5'd5; bus.waE = 5'd5;
        bus.resE = 3'(RES_ALU); bus.tuseRsD = TUSE_D;
        #2;
        cmp("reset.stall",   bus.stall,   1'b0);
        cmp("reset.DEMWclr", bus.DEMWclr, 1'b0);
        cmp("reset.pcExc",   bus.pcExc,   1'b0);
        cmp("reset.mdBusy",  bus.mdBusy,  1'b0);
        drive_idle();
        @(negedge clk);
        rst = 1'b0;

        // Decode table.
        for (int i = 0; i < 16; i++) begin
            next_cycle();
            drive_idle();
            bus.ra1D = vecs[i].ra1; bus.ra2D = vecs[i].ra2;
            bus.tuseRsD = vecs[i].tr; bus.tuseRtD = vecs[i].tt;
            bus.waE = vecs[i].wae; bus.waM = vecs[i].wam;
            bus.resE = vecs[i].rese; bus.resM = vecs[i].resm;
            bus.mdUseD = vecs[i].mduse;
            expect_now($sformatf("vec%0d", i), vecs[i].exp_stall, 1'b0, 1'b0, 1'b0);
        end

        // Load-use: one stall cycle, cleared once the load sits in M.
        next_cycle(); drive_idle();
        bus.resE = 3'(RES_DM); bus.waE = 5'd8; bus.ra1D = 5'd8; bus.tuseRsD = TUSE_E;
        expect_now("loaduse.c0", 1'b1, 1'b0, 1'b0, 1'b0);
        next_cycle();
        bus.resE = 3'(RES_NW); bus.waE = 5'd0; bus.resM = 3'(RES_DM); bus.waM = 5'd8;
        expect_now("loaduse.c1", 1'b0, 1'b0, 1'b0, 1'b0);

        // Exception while a data stall is pending: two flush cycles, then RUN.
        next_cycle(); drive_idle();
        bus.resE = 3'(RES_DM); bus.waE = 5'd8; bus.ra1D = 5'd8; bus.tuseRsD = TUSE_D;
        bus.excReqM = 1'b1;
        expect_now("excstall.c0", 1'b0, 1'b1, 1'b1, 1'b0);
        next_cycle(); bus.excReqM = 1'b0;
        expect_now("excstall.c1", 1'b0, 1'b1, 1'b1, 1'b0);
        next_cycle();
        expect_now("excstall.run", 1'b1, 1'b0, 1'b0, 1'b0);

        // Eret with no hazard: one ERETW bubble.
        next_cycle(); drive_idle(); bus.eretD = 1'b1;
        expect_now("eret.c0", 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle(); bus.eretD = 1'b0;
        expect_now("eret.wait", 1'b1, 1'b0, 1'b0, 1'b0);
        next_cycle();
        expect_now("eret.done", 1'b0, 1'b0, 1'b0, 1'b0);

        // Eret blocked by a stall stays in RUN.
        next_cycle(); drive_idle(); bus.eretD = 1'b1;
        bus.resE = 3'(RES_ALU); bus.waE = 5'd4; bus.ra2D = 5'd4; bus.tuseRtD = TUSE_D;
        expect_now("eretstall.c0", 1'b1, 1'b0, 1'b0, 1'b0);
        next_cycle(); drive_idle();
        expect_now("eretstall.c1", 1'b0, 1'b0, 1'b0, 1'b0);

        // Exception outranks eret in the same cycle: FLUSH, no ERETW bubble.
        next_cycle(); drive_idle(); bus.eretD = 1'b1; bus.excReqM = 1'b1;
        expect_now("exceret.c0", 1'b0, 1'b1, 1'b1, 1'b0);
        next_cycle(); drive_idle();
        expect_now("exceret.c1", 1'b0, 1'b1, 1'b1, 1'b0);
        next_cycle();
        expect_now("exceret.c2", 1'b0, 1'b0, 1'b0, 1'b0);

        // Divide with mdUseD held: stall for start cycle plus ten busy cycles.
        next_cycle(); drive_idle();
        bus.mdStartE = 1'b1; bus.mdIsDivE = 1'b1; bus.mdUseD = 1'b1;
        expect_now("div.start", MD_EN, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            next_cycle(); bus.mdStartE = 1'b0; bus.mdIsDivE = 1'b0;
            expect_now($sformatf("div.busy%0d", k), MD_EN, 1'b0, 1'b0, MD_EN);
        end
        next_cycle();
        expect_now("div.done", 1'b0, 1'b0, 1'b0, 1'b0);

        // Multiply: five busy cycles.
        next_cycle(); drive_idle(); bus.mdStartE = 1'b1;
        expect_now("mul.start", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            next_cycle(); bus.mdStartE = 1'b0;
            expect_now($sformatf("mul.busy%0d", k), 1'b0, 1'b0, 1'b0, MD_EN);
        end
        next_cycle();
        expect_now("mul.done", 1'b0, 1'b0, 1'b0, 1'b0);

        // Exception does not stop a running count; a start in FLUSH restarts it.
        next_cycle(); drive_idle(); bus.mdStartE = 1'b1;
        expect_now("mdexc.start", 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle(); bus.mdStartE = 1'b0;
        expect_now("mdexc.c1", 1'b0, 1'b0, 1'b0, MD_EN);
        next_cycle(); bus.excReqM = 1'b1; bus.mdStartE = 1'b1; bus.mdIsDivE = 1'b1;
        expect_now("mdexc.exc", 1'b0, 1'b1, 1'b1, MD_EN);
        next_cycle(); bus.excReqM = 1'b0;
        expect_now("mdexc.flush", 1'b0, 1'b1, 1'b1, MD_EN);
        for (int k = 1; k <= 10; k++) begin
            next_cycle(); bus.mdStartE = 1'b0; bus.mdIsDivE = 1'b0;
            expect_now($sformatf("mdexc.re%0d", k), 1'b0, 1'b0, 1'b0, MD_EN);
        end
        next_cycle();
        expect_now("mdexc.done", 1'b0, 1'b0, 1'b0, 1'b0);

        // A start killed by a same-cycle exception never makes the unit busy.
        next_cycle(); bus.excReqM = 1'b1; bus.mdStartE = 1'b1;
        expect_now("mdkill.c0", 1'b0, 1'b1, 1'b1, 1'b0);
        next_cycle(); drive_idle();
        expect_now("mdkill.c1", 1'b0, 1'b1, 1'b1, 1'b0);
        next_cycle();
        expect_now("mdkill.c2", 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-divide at count 6: busy drops without a clock edge.
        next_cycle(); drive_idle(); bus.mdStartE = 1'b1; bus.mdIsDivE = 1'b1;
        expect_now("rstdiv.start", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            next_cycle(); bus.mdStartE = 1'b0; bus.mdIsDivE = 1'b0;
            expect_now($sformatf("rstdiv.busy%0d", k), 1'b0, 1'b0, 1'b0, MD_EN);
        end
        #2 rst = 1'b1;
        #1;
        cmp("rstdiv.async.mdBusy", bus.mdBusy, 1'b0);
        cmp("rstdiv.async.stall",  bus.stall,  1'b0);
        #1 rst = 1'b0;
        next_cycle();
        expect_now("rstdiv.after", 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset during FLUSH forces outputs low and returns to RUN.
        next_cycle(); bus.excReqM = 1'b1;
        expect_now("rstfl.exc", 1'b0, 1'b1, 1'b1, 1'b0);
        next_cycle(); bus.excReqM = 1'b0;
        #1 rst = 1'b1;
        #1;
        cmp("rstfl.async.DEMWclr", bus.DEMWclr, 1'b0);
        cmp("rstfl.async.pcExc",   bus.pcExc,   1'b0);
        #1 rst = 1'b0;
        bus.resE = 3'(RES_ALU); bus.waE = 5'd2; bus.ra1D = 5'd2; bus.tuseRsD = TUSE_D;
        expect_now("rstfl.run", 1'b1, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
